// File: rtl/turbo_pkg.sv
// Shared types and helpers for the turbo encoder front end.
package turbo_pkg;

    localparam int TURBO_W  = 8;
    localparam int ROWS_DEF = 4;
    localparam int COLS_DEF = 4;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Row-in/column-out address. For power-of-two dimensions this is a pure
    // bit rearrangement: the low row bits of idx move to the top, and the
    // remaining upper bits (the column number) move to the bottom.
    function automatic logic [31:0] intlv_addr(input logic [31:0] idx,
                                               input int unsigned row_bits,
                                               input int unsigned col_bits);
        logic [31:0] w_row;
        logic [31:0] w_col;
        w_row = idx & ((32'd1 << row_bits) - 32'd1);
        w_col = idx >> row_bits;
        return (w_row << col_bits) | w_col;
    endfunction

endpackage

// File: rtl/turbo_intlv_mem.sv
// Block storage: one write port, two combinational read ports
// (natural-order and interleaved).
module turbo_intlv_mem
    import turbo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [TURBO_W-1:0] i_wr_data,
    input  logic [AW-1:0]      i_sys_addr,
    input  logic [AW-1:0]      i_int_addr,
    output logic [TURBO_W-1:0] o_sys_data,
    output logic [TURBO_W-1:0] o_int_data
);

    logic [TURBO_W-1:0] r_mem [DEPTH];

    // Byte write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_sys_data = r_mem[i_sys_addr];
    assign o_int_data = r_mem[i_int_addr];

endmodule

// File: rtl/turbo_blk_interleaver.sv
// Block interleaver: fills DEPTH bytes, then drains them as
// (systematic, interleaved) pairs with valid/ready on both sides.
module turbo_blk_interleaver
    import turbo_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int COLS  = COLS_DEF,
    parameter int DEPTH = ROWS * COLS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic [TURBO_W-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [TURBO_W-1:0] out_sys,
    output logic [TURBO_W-1:0] out_int,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [7:0]         blk_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int RB = $clog2(ROWS);
    localparam int CB = $clog2(COLS);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW-1:0] r_rd_idx;
    logic [AW-1:0] w_rd_idx_nxt;
    logic [7:0]    r_blk_cnt;
    logic [7:0]    w_blk_cnt_nxt;
    logic          w_wr_en;
    logic          w_last;
    logic [AW-1:0] w_int_addr;

    assign w_int_addr = AW'(intlv_addr(32'(r_rd_idx), RB, CB));
    assign w_last     = (r_state == DRAIN) && (r_rd_idx == AW'(DEPTH - 1));

    assign in_ready  = (r_state == FILL);
    assign out_valid = (r_state == DRAIN);
    assign out_last  = w_last;
    assign blk_cnt   = r_blk_cnt;

    turbo_intlv_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk        (clk),
        .i_wr_en    (w_wr_en),
        .i_wr_addr  (r_wr_ptr),
        .i_wr_data  (in_data),
        .i_sys_addr (r_rd_idx),
        .i_int_addr (w_int_addr),
        .o_sys_data (out_sys),
        .o_int_data (out_int)
    );

    // State, pointer and block-counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= FILL;
            r_wr_ptr  <= '0;
            r_rd_idx  <= '0;
            r_blk_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_rd_idx  <= w_rd_idx_nxt;
            r_blk_cnt <= w_blk_cnt_nxt;
        end
    end

    // Next-state logic; clear overrides any handshake in the same cycle.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_rd_idx_nxt  = r_rd_idx;
        w_blk_cnt_nxt = r_blk_cnt;
        w_wr_en       = 1'b0;
        if (clear) begin
            w_state_nxt  = FILL;
            w_wr_ptr_nxt = '0;
            w_rd_idx_nxt = '0;
        end else begin
            case (r_state)
                FILL: begin
                    if (in_valid) begin
                        w_wr_en      = 1'b1;
                        w_wr_ptr_nxt = r_wr_ptr + AW'(1);
                        if (r_wr_ptr == AW'(DEPTH - 1)) begin
                            w_state_nxt = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (w_last) begin
                            w_rd_idx_nxt  = '0;
                            w_blk_cnt_nxt = r_blk_cnt + 8'd1;
                            w_state_nxt   = FILL;
                        end else begin
                            w_rd_idx_nxt = r_rd_idx + AW'(1);
                        end
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_turbo_blk_interleaver.sv
// Self-checking bench for turbo_blk_interleaver with a block-level model.
module tb_turbo_blk_interleaver;

    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int DEPTH = ROWS * COLS;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_sys;
    logic [7:0] out_int;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_last;
    logic [7:0] blk_cnt;

    typedef struct packed {
        logic [7:0] s;
        logic [7:0] i;
        logic       l;
    } pair_t;

    pair_t      exp_q[$];
    logic [7:0] part[$];
    logic [7:0] got_sys[$];
    logic [7:0] got_int[$];
    logic       got_last[$];
    logic [7:0] tx [DEPTH];
    logic [7:0] int_tab [DEPTH] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h01, 8'h05, 8'h09, 8'h0D,
                                    8'h02, 8'h06, 8'h0A, 8'h0E, 8'h03, 8'h07, 8'h0B, 8'h0F};
    int  n_tests = 0;
    int  n_fail  = 0;
    int  mblk    = 0;
    int  pops    = 0;
    int  n_wr    = 0;
    bit  log_en  = 1'b0;

    turbo_blk_interleaver #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_sys   (out_sys),
        .out_int   (out_int),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .blk_cnt   (blk_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: collect accepted bytes; a full block becomes DEPTH expected pairs.
    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            part.delete();
            mblk = 0;
        end else begin
            chk("in_ready", 32'(in_ready), 32'(exp_q.size() == 0));
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            chk("blk_cnt", 32'(blk_cnt), 32'(mblk % 256));
            if (exp_q.size() != 0) begin
                chk("out_sys", 32'(out_sys), 32'(exp_q[0].s));
                chk("out_int", 32'(out_int), 32'(exp_q[0].i));
                chk("out_last", 32'(out_last), 32'(exp_q[0].l));
            end
            if (clear) begin
                exp_q.delete();
                part.delete();
            end else begin
                if (in_valid && in_ready) begin
                    n_wr++;
                    part.push_back(in_data);
                    if (part.size() == DEPTH) begin
                        for (int k = 0; k < DEPTH; k++) begin
                            pair_t e;
                            e.s = part[k];
                            e.i = part[(k % ROWS) * COLS + k / ROWS];
                            e.l = (k == DEPTH - 1);
                            exp_q.push_back(e);
                        end
                        part.delete();
                    end
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    if (log_en) begin
                        got_sys.push_back(out_sys);
                        got_int.push_back(out_int);
                        got_last.push_back(out_last);
                    end
                    if (exp_q[0].l) mblk++;
                    void'(exp_q.pop_front());
                    pops++;
                end
            end
        end
    end

    // Present n bytes of tx; mode 0 back-to-back, 1 alternating gaps, 2 random gaps.
    task automatic send(input int n, input int mode);
        int i = 0;
        int guard = 0;
        bit acc;
        while (i < n && guard < 400) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = ((guard % 2) == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = tx[i];
            acc = in_valid && in_ready;
            tick();
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        if (i < n) chk("send_timeout", 32'(i), 32'(n));
    endtask

    task automatic wait_drain(input bit rnd);
        int g = 0;
        while ((exp_q.size() != 0 || in_ready !== 1'b1) && g < 500) begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            tick();
            g++;
        end
        out_ready = 1'b1;
        if (g >= 500) chk("drain_timeout", 32'(g), 32'(0));
    endtask

    task automatic fill_tx(input int base, input bit rnd);
        for (int k = 0; k < DEPTH; k++) begin
            tx[k] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + k);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        int p0;
        // Reset / idle
        #1 rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_blk_cnt", 32'(blk_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Nominal block 0x00..0x0F
        out_ready = 1'b1;
        log_en = 1'b1;
        fill_tx(0, 1'b0);
        send(DEPTH, 0);
        chk("valid_after_last", 32'(out_valid), 32'd1);
        wait_drain(1'b0);
        log_en = 1'b0;
        chk("nom_pairs", 32'(got_sys.size()), 32'(DEPTH));
        for (int k = 0; k < DEPTH && k < got_sys.size(); k++) begin
            chk("nom_sys", 32'(got_sys[k]), 32'(k));
            chk("nom_int", 32'(got_int[k]), 32'(int_tab[k]));
            chk("nom_last", 32'(got_last[k]), 32'(k == DEPTH - 1));
        end
        chk("nom_blk_cnt", 32'(blk_cnt), 32'd1);
        chk("nom_in_ready", 32'(in_ready), 32'd1);

        // Backpressure at rd_idx=5
        send(DEPTH, 0);
        repeat (5) tick();
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("bp_hold_sys", 32'(out_sys), 32'h05);
            chk("bp_hold_int", 32'(out_int), 32'h05);
            tick();
        end
        chk("bp_hold_sys", 32'(out_sys), 32'h05);
        out_ready = 1'b1;
        tick();
        chk("bp_next_sys", 32'(out_sys), 32'h06);
        chk("bp_next_int", 32'(out_int), 32'h09);
        wait_drain(1'b0);

        // Input gaps
        fill_tx(0, 1'b1);
        n_wr = 0;
        send(DEPTH, 1);
        chk("gap_writes", 32'(n_wr), 32'(DEPTH));
        wait_drain(1'b0);

        // Clear during fill after 7 bytes
        fill_tx(0, 1'b1);
        send(7, 0);
        clear = 1'b1;
        in_valid = 1'b1;
        in_data = 8'hAA;
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("clr_in_ready", 32'(in_ready), 32'd1);
        chk("clr_out_valid", 32'(out_valid), 32'd0);
        fill_tx(16, 1'b0);
        out_ready = 1'b0;
        send(DEPTH, 0);
        chk("clr_first_sys", 32'(out_sys), 32'h10);
        chk("clr_first_int", 32'(out_int), 32'h10);
        out_ready = 1'b1;
        tick();
        chk("clr_second_sys", 32'(out_sys), 32'h11);
        chk("clr_second_int", 32'(out_int), 32'h14);
        wait_drain(1'b0);

        // Clear during drain with concurrent pop
        fill_tx(0, 1'b1);
        send(DEPTH, 0);
        repeat (3) tick();
        b = blk_cnt;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clrd_blk_cnt", 32'(blk_cnt), 32'(b));
        chk("clrd_out_valid", 32'(out_valid), 32'd0);
        chk("clrd_in_ready", 32'(in_ready), 32'd1);

        // Random gaps and backpressure
        for (int n = 0; n < 6; n++) begin
            fill_tx(0, 1'b1);
            send(DEPTH, 2);
            wait_drain(1'b1);
        end

        // Asynchronous reset mid-drain
        fill_tx(0, 1'b1);
        send(DEPTH, 0);
        repeat (4) tick();
        #1 rst = 1'b0;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_blk_cnt", 32'(blk_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Counter wrap over 256 blocks
        p0 = pops;
        for (int n = 0; n < 256; n++) begin
            fill_tx(0, 1'b1);
            send(DEPTH, 0);
            wait_drain(1'b0);
        end
        chk("wrap_blk_cnt", 32'(blk_cnt), 32'd0);
        chk("wrap_pairs", 32'(pops - p0), 32'(256 * DEPTH));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/turbo_blk_interleaver.md
Name: turbo_blk_interleaver

Overview:
- Upstream stage of the turbo encoder datapath.
- Buffers one block of DEPTH input bytes, then replays the block as byte pairs: systematic (natural order) plus interleaved (row-in/column-out order).
- The systematic stream feeds the first constituent encoder; the interleaved stream feeds the second.
- Valid/ready on both sides; single buffer with a fill phase then a drain phase.

Parameters:
- ROWS, 4, interleaver matrix rows (power of 2, ≥2)
- COLS, 4, interleaver matrix columns (power of 2, ≥2)
- DEPTH, ROWS*COLS, bytes per block (derived; not overridden)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous abort: discard block, return to FILL
- in_data  in  8  input byte
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts a byte
- out_sys  out  8  systematic byte, natural order
- out_int  out  8  interleaved byte
- out_valid  out  1  out_sys/out_int valid
- out_ready  in  1  downstream accepts the pair
- out_last  out  1  current pair is the last of the block
- blk_cnt  out  8  completed blocks, wraps 255→0

Behaviour:
- Storage: DEPTH×8 register array; wr_ptr and rd_idx are each log2(DEPTH) bits; state register.
- Reset (rst=0, asynchronous):
  - state=FILL; wr_ptr=0, rd_idx=0, blk_cnt=0.
  - in_ready=1 after reset release; out_valid=0, out_last=0.
  - Array contents are not reset.
- FILL:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: mem[wr_ptr]←in_data; wr_ptr++.
  - When the byte written is at wr_ptr=DEPTH-1: wr_ptr wraps to 0, state→DRAIN.
- DRAIN:
  - in_ready=0, out_valid=1.
  - out_sys=mem[rd_idx].
  - out_int=mem[(rd_idx mod ROWS)*COLS + rd_idx/ROWS], using pure bit-slicing.
  - out_last=1 iff rd_idx=DEPTH-1.
  - Outputs are combinational from registered rd_idx/array; they are valid the first DRAIN cycle, i.e. 1 cycle after the last write.
  - On out_valid&out_ready: rd_idx++.
  - If out_last: rd_idx→0, blk_cnt++, state→FILL (in_ready=1 next cycle).
- Backpressure: while out_ready=0, out_sys/out_int/out_last are held stable and rd_idx does not advance.
- Throughput: DEPTH fill cycles + DEPTH drain cycles + 0 bubble cycles; no overlap of fill and drain.
- clear=1 (either state, highest priority after reset):
  - Next cycle: state=FILL, wr_ptr=0, rd_idx=0; blk_cnt unchanged.
  - Any concurrent input or output handshake in that cycle is ignored; no write, no count.
- in_valid in DRAIN has no effect; in_data is not sampled.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- Reset mid-block: partial block is lost; behaviour is as from power-up.

Decomposition:
- Shared package turbo_pkg:
  - TURBO_W=8
  - default ROWS/COLS
  - state enum {FILL, DRAIN}
  - function intlv_addr(idx) returning the row/column permuted address
- One natural sub-module: turbo_intlv_mem, holding the DEPTH×8 array with one write port and two combinational read ports (sys, int).
- FSM and pointers stay in the top.

Test Plan:
- Reset/idle: assert rst=0 mid-clock → in_ready=1, out_valid=0, blk_cnt=0 immediately (asynchronous); array contents ignored.
- Nominal block:
  - Stimulus: write bytes 0x00..0x0F back-to-back, out_ready=1.
  - Required: out_valid rises 1 cycle after byte 0x0F.
  - out_sys = 0x00..0x0F in order.
  - out_int = 00,04,08,0C,01,05,09,0D,02,06,0A,0E,03,07,0B,0F.
  - out_last only with sys=0x0F, int=0x0F; blk_cnt=1; in_ready=1 the following cycle.
- Backpressure: during drain, hold out_ready=0 for 3 cycles at rd_idx=5 → pair (0x05,0x05) held stable, rd_idx unchanged; resumes with (0x06,0x09).
- Input gaps: in_valid toggled 1/0 every cycle during fill → exactly 16 writes recorded; drain order identical to nominal.
- Clear:
  - Clear after 7 bytes written → next cycle wr_ptr=0, FILL, no output; a fresh 16-byte block 0x10..0x1F then drains first pair (0x10,0x10), second pair (0x11,0x14).
  - Clear asserted in DRAIN with out_ready=1 on the same cycle → that pair is not counted and blk_cnt is unchanged.
- Counter wrap: stream 256 full blocks → blk_cnt returns to 0; no lost or duplicated pairs.
